// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared types and helpers for the nn output stream blocks
package nn_stream_pkg;

    typedef enum logic {SCAN, HOLD} argmax_state_t;

    // An index into a single-entry vector still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - combinational signed compare-select for a running argmax
module argmax_cmp #(
    parameter int T  = 16,
    parameter int IW = 3
) (
    input  logic [T-1:0]  cur_max,
    input  logic [IW-1:0] cur_idx,
    input  logic [T-1:0]  din,
    input  logic [IW-1:0] pos,
    input  logic          first,
    output logic [T-1:0]  new_max,
    output logic [IW-1:0] new_idx
);

    logic take;

    // Strict greater-than so that ties keep the earliest position.
    always_comb begin
        take    = first || ($signed(din) > $signed(cur_max));
        new_max = take ? din : cur_max;
        new_idx = take ? pos : cur_idx;
    end

endmodule

// File: rtl/stream_argmax_5_16.sv
// rtl/stream_argmax_5_16.sv - per-vector argmax over a valid/ready stream of signed words
module stream_argmax_5_16
    import nn_stream_pkg::*;
#(
    parameter int M  = 5,
    parameter int T  = 16,
    parameter int IW = clog2_min1(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [T-1:0]  data_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [T-1:0]  data_out,
    output logic [IW-1:0] idx_out
);

    localparam logic [IW-1:0] LAST_POS = IW'(M - 1);

    argmax_state_t state;
    logic [IW-1:0] cnt;
    logic [T-1:0]  cur_max;
    logic [IW-1:0] cur_idx;
    logic [T-1:0]  new_max;
    logic [IW-1:0] new_idx;
    logic          in_xfer;
    logic          is_last;

    // While a result is pending, a new word may only enter when it is drained.
    assign s_ready = (state == SCAN) || m_ready;
    assign in_xfer = s_valid && s_ready;
    assign is_last = (cnt == LAST_POS);

    // cnt is always 0 in HOLD, so a word arriving in the handoff cycle starts a vector.
    argmax_cmp #(
        .T  (T),
        .IW (IW)
    ) u_cmp (
        .cur_max (cur_max),
        .cur_idx (cur_idx),
        .din     (data_in),
        .pos     (cnt),
        .first   (cnt == '0),
        .new_max (new_max),
        .new_idx (new_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SCAN;
            cnt      <= '0;
            m_valid  <= 1'b0;
            data_out <= '0;
            idx_out  <= '0;
            cur_max  <= '0;
            cur_idx  <= '0;
        end else if (in_xfer) begin
            if (is_last) begin
                state    <= HOLD;
                cnt      <= '0;
                m_valid  <= 1'b1;
                data_out <= new_max;
                idx_out  <= new_idx;
            end else begin
                state   <= SCAN;
                cnt     <= cnt + IW'(1);
                m_valid <= 1'b0;
                cur_max <= new_max;
                cur_idx <= new_idx;
            end
        end else if (m_valid && m_ready) begin
            state   <= SCAN;
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_argmax_5_16.sv
// tb/tb_stream_argmax_5_16.sv - self-checking bench for stream_argmax_5_16
module tb_stream_argmax_5_16;

    localparam int M  = 5;
    localparam int T  = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [T-1:0]  data_in;
    logic          m_valid;
    logic          m_ready;
    logic [T-1:0]  data_out;
    logic [IW-1:0] idx_out;

    int checks = 0;
    int errors = 0;

    stream_argmax_5_16 dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .data_out (data_out),
        .idx_out  (idx_out)
    );

    always #5 clk = ~clk;

    // Reference: find the largest value, then the first position holding it.
    function automatic logic [T+IW-1:0] ref_argmax(input logic [T-1:0] v[M]);
        int best;
        int pos;
        best = $signed(v[0]);
        for (int i = 1; i < M; i++)
            if ($signed(v[i]) > best) best = $signed(v[i]);
        pos = 0;
        for (int i = M - 1; i >= 0; i--)
            if ($signed(v[i]) == best) pos = i;
        return {T'(best), IW'(pos)};
    endfunction

    function automatic logic [T-1:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 16'h7fff;
            1:       return 16'h8000;
            2, 3:    return T'(int'($urandom_range(0, 6)) - 3);
            default: return T'($urandom);
        endcase
    endfunction

    task automatic drive_word(input logic [T-1:0] d, output bit timeout);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        data_in = d;
        #1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        timeout = !s_ready;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        data_in = '0;
    endtask

    task automatic send_vector(input logic [T-1:0] v[M]);
        bit to;
        for (int i = 0; i < M; i++) begin
            drive_word(v[i], to);
            if (to) begin
                errors++;
                $display("FAIL send_timeout: s_ready=%0b required 1 within 50 cycles", s_ready);
            end
        end
    endtask

    task automatic get_result(output logic [T-1:0] d, output logic [IW-1:0] i, output bit timeout);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        timeout = !m_valid;
        d = data_out;
        i = idx_out;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = '0;
        reset   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b required 0", m_valid); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h required 0000", data_out); end
        checks++;
        if (idx_out !== '0) begin errors++; $display("FAIL reset_idx_out: got %0d required 0", idx_out); end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
    endtask

    task automatic test_vector(input string name, input logic [T-1:0] v[M],
                               input logic [T-1:0] exp_d, input logic [IW-1:0] exp_i);
        logic [T-1:0]  d;
        logic [IW-1:0] i;
        bit to;
        send_vector(v);
        get_result(d, i, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout: m_valid=0 required 1", name); end
        checks++;
        if (d !== exp_d) begin errors++; $display("FAIL %s_data: got %h required %h", name, d, exp_d); end
        checks++;
        if (i !== exp_i) begin errors++; $display("FAIL %s_idx: got %0d required %0d", name, i, exp_i); end
    endtask

    task automatic test_directed();
        logic [T-1:0] v[M];
        v = '{16'd3, 16'hfffe, 16'd7, 16'd7, 16'd1};
        test_vector("tie", v, 16'h0007, 3'd2);
        v = '{16'hfffb, 16'hffff, 16'hfff8, 16'hffff, 16'hfff7};
        test_vector("negative", v, 16'hffff, 3'd1);
        v = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        test_vector("all_min", v, 16'h8000, 3'd0);
        v = '{16'h8000, 16'h0000, 16'h7fff, 16'h7ffe, 16'h7fff};
        test_vector("max_pos", v, 16'h7fff, 3'd2);
    endtask

    task automatic test_stall();
        logic [T-1:0] v[M];
        v = '{16'd10, 16'd40, 16'd20, 16'd30, 16'd0};
        send_vector(v);
        @(negedge clk);
        s_valid = 1'b1;
        data_in = 16'd123;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid c%0d: got %0b required 1", c, m_valid); end
            checks++;
            if (data_out !== 16'd40) begin errors++; $display("FAIL stall_data c%0d: got %h required 0028", c, data_out); end
            checks++;
            if (idx_out !== 3'd1) begin errors++; $display("FAIL stall_idx c%0d: got %0d required 1", c, idx_out); end
            checks++;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready c%0d: got %0b required 0", c, s_ready); end
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: m_valid=%0b required 0", m_valid); end
        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        test_vector("after_stall", v, 16'd5, 3'd4);
    endtask

    task automatic test_back_to_back();
        logic [T-1:0] words[4*M];
        logic [T-1:0] v[M];
        logic [T+IW-1:0] r;
        bit exp_valid;
        for (int k = 0; k < 4 * M; k++) words[k] = rand_word();
        m_ready = 1'b1;
        for (int c = 0; c <= 4 * M; c++) begin
            @(negedge clk);
            s_valid = (c < 4 * M);
            data_in = (c < 4 * M) ? words[c] : '0;
            #1;
            exp_valid = (c >= M) && (c % M == 0);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL b2b_m_valid c%0d: got %0b required %0b", c, m_valid, exp_valid); end
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready c%0d: got %0b required 1", c, s_ready); end
            if (exp_valid) begin
                for (int k = 0; k < M; k++) v[k] = words[c - M + k];
                r = ref_argmax(v);
                checks++;
                if ({data_out, idx_out} !== r)
                    begin errors++; $display("FAIL b2b_result c%0d: got %h/%0d required %h/%0d", c, data_out, idx_out, r[T+IW-1:IW], r[IW-1:0]); end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [T-1:0] v[M];
        bit to;
        for (int k = 0; k < 3; k++) drive_word(16'd50, to);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %0b required 0", m_valid); end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready: got %0b required 1", s_ready); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL rstmid_data_out: got %h required 0000", data_out); end
        @(negedge clk);
        reset = 1'b1;
        v = '{16'd1, 16'd9, 16'd2, 16'd0, 16'd0};
        test_vector("after_reset", v, 16'd9, 3'd1);
    endtask

    task automatic test_random();
        logic [T-1:0]    cur[$];
        logic [T+IW-1:0] exp_q[$];
        logic [T-1:0]    v[M];
        logic [T+IW-1:0] r;
        int vectors = 0;
        int cycles  = 0;
        bit exp_ready;
        while ((vectors < 2000 || exp_q.size() != 0) && cycles < 60000) begin
            @(negedge clk);
            s_valid = (vectors < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_in = s_valid ? rand_word() : 'x;
            m_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = (exp_q.size() == 0) || m_ready;
            checks++;
            if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_s_ready cyc%0d: got %0b required %0b", cycles, s_ready, exp_ready); end
            checks++;
            if (m_valid !== (exp_q.size() != 0))
                begin errors++; $display("FAIL rand_m_valid cyc%0d: got %0b required %0b", cycles, m_valid, exp_q.size() != 0); end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                r = exp_q.pop_front();
                checks++;
                if ({data_out, idx_out} !== r)
                    begin errors++; $display("FAIL rand_result cyc%0d: got %h/%0d required %h/%0d", cycles, data_out, idx_out, r[T+IW-1:IW], r[IW-1:0]); end
            end
            if (s_valid && s_ready) begin
                cur.push_back(data_in);
                if (cur.size() == M) begin
                    for (int k = 0; k < M; k++) v[k] = cur[k];
                    exp_q.push_back(ref_argmax(v));
                    cur.delete();
                    vectors++;
                end
            end
            cycles++;
        end
        checks++;
        if (vectors < 2000 || exp_q.size() != 0)
            begin errors++; $display("FAIL rand_budget: vectors=%0d pending=%0d required 2000/0", vectors, exp_q.size()); end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
